// File: rtl/deltat_axis_packer.sv
// deltat_axis_packer: pairs delta-T words into 2*WORDSIZE AXI4-Stream beats,
// buffers them in a first-word-fall-through FIFO, frames packets with TLAST,
// flushes a lone pending word after an idle timeout, and counts overflow drops.
module deltat_axis_packer #(
    parameter int WORDSIZE     = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int PKT_BEATS    = 256,
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WORDSIZE-1:0]     inData,
    input  logic                    inWrEn,
    input  logic                    clr,
    output logic [2*WORDSIZE-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [31:0]             dropCnt,
    output logic                    overflow
);

    localparam int DW = 2 * WORDSIZE;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(FLUSH_CYCLES + 1);
    localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

    // Saturating add used by the drop counter so it sticks at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic                pend_q, pend_d;
    logic [WORDSIZE-1:0] held_q, held_d;
    logic [TW-1:0]       idle_q, idle_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
    logic [31:0]         drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic [DW:0]         mem_q [FIFO_DEPTH];

    logic          empty, full, pop;
    logic          push_vld, push_pad, push_last, push_ok, push_drop;
    logic [DW-1:0] push_word;
    logic [DW:0]   head;

    // Pointers carry a wrap bit so full and empty are exact at 0 and FIFO_DEPTH.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && m_axis_tready;

    // Pairing register and idle timer: decide whether a beat is formed this edge.
    always_comb begin
        pend_d    = pend_q;
        held_d    = held_q;
        idle_d    = idle_q;
        push_vld  = 1'b0;
        push_pad  = 1'b0;
        push_word = '0;
        if (inWrEn) begin
            idle_d = '0;
            if (pend_q) begin
                // A sample arriving on the timeout edge still pairs normally.
                push_vld  = 1'b1;
                push_word = {inData, held_q};
                pend_d    = 1'b0;
            end else begin
                held_d = inData;
                pend_d = 1'b1;
            end
        end else if (pend_q) begin
            if (idle_q == TW'(FLUSH_CYCLES - 1)) begin
                // Upper half zero marks the padded flush beat.
                push_vld  = 1'b1;
                push_pad  = 1'b1;
                push_word = {{WORDSIZE{1'b0}}, held_q};
                pend_d    = 1'b0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    // Push acceptance, packet framing, pointer and drop bookkeeping.
    always_comb begin
        push_last = push_pad || (beat_q == BW'(PKT_BEATS - 1));
        push_ok   = push_vld && (!full || pop);
        push_drop = push_vld && !push_ok;

        beat_d = beat_q;
        if (push_ok) begin
            beat_d = push_last ? '0 : beat_q + BW'(1);
        end

        wr_d = wr_q + {{AW{1'b0}}, push_ok};
        rd_d = rd_q + {{AW{1'b0}}, pop};

        // A drop on the same edge as clr is counted on top of the cleared value.
        drop_d = clr ? 32'd0 : drop_q;
        ovf_d  = clr ? 1'b0 : ovf_q;
        if (push_drop) begin
            drop_d = sat_add32(drop_d, push_pad ? 2'd1 : 2'd2);
            ovf_d  = 1'b1;
        end
    end

    // Control state: cleared asynchronously, discarding any partial pair or packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            idle_q <= '0;
            beat_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            idle_q <= idle_d;
            beat_q <= beat_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    // Held word: data only, its validity is tracked by pend_q.
    always_ff @(posedge clk) begin
        held_q <= held_d;
    end

    // FIFO storage of {tlast, tdata}; contents are meaningful only between pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= {push_last, push_word};
        end
    end

    // Fall-through head, forced to zero while empty so reset shows clean outputs.
    always_comb begin
        head          = mem_q[rd_q[AW-1:0]];
        m_axis_tvalid = !empty;
        m_axis_tdata  = empty ? '0 : head[DW-1:0];
        m_axis_tlast  = empty ? 1'b0 : head[DW];
    end

    assign dropCnt  = drop_q;
    assign overflow = ovf_q;

endmodule
